path_sequencer: RTL and testbench
=================================

# path_sequencer

Controller that moves the sprite anchor point on the 96x64 OLED along a fixed closed path of waypoints, one pixel per step tick. It sits between the screen-state FSM and the pixel renderer. The FSM gates it with `enable` and launches laps with `start`; the renderer reads `pos_x`/`pos_y`. Each move is diagonal-capable: both axes step toward the current target on the same tick.

## Interface
Parameters:
- `N_WP`, default 6: number of waypoints in the path table, index 0 being home.
- `X_W`, default 7: width of the x coordinate.
- `Y_W`, default 6: width of the y coordinate.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: level input. Low forces the block idle at home.
- `start`  in  1: single-cycle pulse that begins a lap from IDLE.
- `pause`  in  1: level input. While high, step ticks are ignored in RUN.
- `loop_mode`  in  1: 1 means restart automatically after a lap; 0 means stop after one lap.
- `step_tick`  in  1: single-cycle pulse. Each pulse allows at most one pixel step.
- `pos_x`  out  X_W: current x position.
- `pos_y`  out  Y_W: current y position.
- `seg_idx`  out  3: index of the current target waypoint.
- `busy`  out  1: high in RUN.
- `at_wp`  out  1: one-cycle pulse on arrival at any waypoint.
- `lap_done`  out  1: one-cycle pulse on arrival back at home.

## Operation
- Path table: WP0 (84,0) home, WP1 (84,52), WP2 (42,52), WP3 (42,26), WP4 (63,26), WP5 (63,0). The path then returns to WP0.
- Lap length is 188 steps.
- States are IDLE and RUN. Pause is a qualifier inside RUN, not a separate state.
- IDLE:
  - Position is held at home, `seg_idx`=0, `busy`=0.
  - `start`=1 with `enable`=1 moves to RUN with `seg_idx`=1.
- RUN, on a tick with `pause`=0, per axis:
  - If current < target, add 1.
  - If current > target, subtract 1.
  - Otherwise hold.
  - Arithmetic is unsigned at native width. No wrap can occur because all targets lie in range.
- Arrival:
  - Arrival means the next position equals the target.
  - On that same edge, `at_wp` pulses.
  - `seg_idx` advances to (`seg_idx`+1) mod `N_WP`.
- Arrival at WP0 (lap end):
  - `lap_done` and `at_wp` both pulse.
  - If `loop_mode`=1, stay in RUN with `seg_idx`=1.
  - If `loop_mode`=0, go to IDLE.
- `enable`=0 in any state:
  - Same edge: go to IDLE, position to home, `seg_idx`=0, no pulses.
  - Takes priority over `start`, ticks and arrival.
- `start` while in RUN is ignored. A lap never restarts mid-path.
- Ticks while in IDLE or while paused are dropped, not queued.
- `pause` dropping with a simultaneous tick: the tick is honoured.

## Timing
- Reset values: state IDLE, `pos_x`=84, `pos_y`=0, `seg_idx`=0, `busy`=0, `at_wp`=0, `lap_done`=0.
- All outputs are registered.
- Step latency: a tick sampled at edge N gives the new position visible after edge N.
- `at_wp` and `lap_done` are high for exactly the cycle following the arrival edge.
- `busy` rises in the cycle after the `start` edge.
- `busy` falls in the same cycle that `lap_done` is high (when `loop_mode`=0).
- Reset mid-lap: on the next edge all outputs return to their reset values.
- Back-to-back ticks on consecutive cycles are legal. The block accepts one step per cycle.

## Structure
- Shared package `path_pkg` holds:
  - the state encoding (IDLE, RUN);
  - `HOME_X`=84, `HOME_Y`=0;
  - the waypoint X and Y constant arrays;
  - coordinate widths.
- Sub-module `axis_stepper` is the combinational next-coordinate calculation for one axis.
  - Inputs: current value, target.
  - Outputs: next value, `equal` flag.
  - Instantiated twice, once for x and once for y.
- FSM, `seg_idx` counter and pulse registers live in `path_sequencer`.

## Test plan
- Reset then idle: assert `reset` 2 cycles, then issue 10 ticks with no `start` -> (84,0), `seg_idx`=0, `busy`=0 throughout.
- First segment: `start`, then 52 ticks -> (84,52); `at_wp` pulses once; `seg_idx`=2.
- Full lap, no loop: `loop_mode`=0, `start`, 188 ticks -> (84,0); `lap_done` and `at_wp` pulse together; `busy`=0; further ticks leave position at (84,0).
- Loop: `loop_mode`=1, 376 ticks -> `lap_done` pulses exactly twice (after tick 188 and tick 376); `busy` stays 1; `seg_idx`=1 after each lap end.
- Pause: after 30 ticks, hold `pause`=1 for 20 ticks, then release and give 22 ticks -> (84,52) reached on tick 52 counted excluding paused ticks.
- Enable drop and restart: at position (42,40), with `enable`=0 coincident with a tick -> next cycle (84,0), `seg_idx`=0, no `at_wp`. Then `enable`=1 plus `start` -> lap restarts at `seg_idx`=1.

Source files
------------

// File: rtl/path_pkg.sv
// Shared constants for the sprite path sequencer: state encoding, home point,
// waypoint table and coordinate widths.
package path_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int PATH_N_WP = 6;
    localparam int PATH_X_W  = 7;
    localparam int PATH_Y_W  = 6;

    localparam logic [PATH_X_W-1:0] HOME_X = 7'd84;
    localparam logic [PATH_Y_W-1:0] HOME_Y = 6'd0;

    // Index 0 is home; the path closes by returning from the last entry to it.
    localparam logic [PATH_X_W-1:0] WP_X [PATH_N_WP] = '{7'd84, 7'd84, 7'd42, 7'd42, 7'd63, 7'd63};
    localparam logic [PATH_Y_W-1:0] WP_Y [PATH_N_WP] = '{6'd0,  6'd52, 6'd52, 6'd26, 6'd26, 6'd0};

    function automatic logic [PATH_X_W-1:0] wp_x(input logic [2:0] idx);
        return (int'(idx) < PATH_N_WP) ? WP_X[idx] : HOME_X;
    endfunction

    function automatic logic [PATH_Y_W-1:0] wp_y(input logic [2:0] idx);
        return (int'(idx) < PATH_N_WP) ? WP_Y[idx] : HOME_Y;
    endfunction

endpackage

// File: rtl/axis_stepper.sv
// One-axis next-coordinate calculation: move one pixel toward the target and
// flag when the resulting coordinate lands on it.
module axis_stepper #(
    parameter int W = 7
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] nxt,
    output logic         equal
);

    always_comb begin
        nxt = cur;
        if (cur < tgt)
            nxt = cur + 1'b1;
        else if (cur > tgt)
            nxt = cur - 1'b1;
        equal = (nxt == tgt);
    end

endmodule

// File: rtl/path_sequencer.sv
// Walks the sprite anchor around the fixed waypoint loop, one pixel per
// accepted step tick, with diagonal-capable moves.
module path_sequencer
    import path_pkg::*;
#(
    parameter int N_WP = PATH_N_WP,
    parameter int X_W  = PATH_X_W,
    parameter int Y_W  = PATH_Y_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           start,
    input  logic           pause,
    input  logic           loop_mode,
    input  logic           step_tick,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [2:0]     seg_idx,
    output logic           busy,
    output logic           at_wp,
    output logic           lap_done
);

    state_t         state, state_n;
    logic [X_W-1:0] pos_x_n, tgt_x, step_x;
    logic [Y_W-1:0] pos_y_n, tgt_y, step_y;
    logic [2:0]     seg_n, seg_inc;
    logic           at_wp_n, lap_done_n;
    logic           eq_x, eq_y, do_step;

    assign tgt_x   = X_W'(wp_x(seg_idx));
    assign tgt_y   = Y_W'(wp_y(seg_idx));
    assign seg_inc = (seg_idx == 3'(N_WP - 1)) ? 3'd0 : seg_idx + 3'd1;
    assign do_step = (state == S_RUN) && step_tick && !pause;
    assign busy    = (state == S_RUN);

    axis_stepper #(.W(X_W)) u_axis_x (.cur(pos_x), .tgt(tgt_x), .nxt(step_x), .equal(eq_x));
    axis_stepper #(.W(Y_W)) u_axis_y (.cur(pos_y), .tgt(tgt_y), .nxt(step_y), .equal(eq_y));

    always_comb begin
        state_n    = state;
        pos_x_n    = pos_x;
        pos_y_n    = pos_y;
        seg_n      = seg_idx;
        at_wp_n    = 1'b0;
        lap_done_n = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
            pos_x_n = X_W'(HOME_X);
            pos_y_n = Y_W'(HOME_Y);
            seg_n   = 3'd0;
        end else if (state == S_IDLE) begin
            pos_x_n = X_W'(HOME_X);
            pos_y_n = Y_W'(HOME_Y);
            seg_n   = 3'd0;
            if (start) begin
                state_n = S_RUN;
                seg_n   = 3'd1;
            end
        end else if (do_step) begin
            pos_x_n = step_x;
            pos_y_n = step_y;
            if (eq_x && eq_y) begin
                at_wp_n = 1'b1;
                // Target 0 is home, so arriving there closes the lap.
                if (seg_idx == 3'd0) begin
                    lap_done_n = 1'b1;
                    if (loop_mode) begin
                        seg_n = 3'd1;
                    end else begin
                        state_n = S_IDLE;
                        seg_n   = 3'd0;
                    end
                end else begin
                    seg_n = seg_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pos_x    <= X_W'(HOME_X);
            pos_y    <= Y_W'(HOME_Y);
            seg_idx  <= 3'd0;
            at_wp    <= 1'b0;
            lap_done <= 1'b0;
        end else begin
            state    <= state_n;
            pos_x    <= pos_x_n;
            pos_y    <= pos_y_n;
            seg_idx  <= seg_n;
            at_wp    <= at_wp_n;
            lap_done <= lap_done_n;
        end
    end

endmodule

// File: tb/tb_path_sequencer.sv
// Bench for path_sequencer: scenario tasks plus randomized traffic, checked
// against a lap-step-count model of the waypoint path.
module tb_path_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       loop_mode = 1'b0;
    logic       step_tick = 1'b0;
    logic [6:0] pos_x;
    logic [5:0] pos_y;
    logic [2:0] seg_idx;
    logic       busy, at_wp, lap_done;

    int tests = 0;
    int fails = 0;

    path_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .pause(pause),
        .loop_mode(loop_mode), .step_tick(step_tick), .pos_x(pos_x), .pos_y(pos_y),
        .seg_idx(seg_idx), .busy(busy), .at_wp(at_wp), .lap_done(lap_done)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {pos_x, pos_y, seg_idx, busy, at_wp, lap_done};

    // Reference: lap precomputed as a list of points; state is just the step count.
    int wx[6] = '{84, 84, 42, 42, 63, 63};
    int wy[6] = '{0, 52, 52, 26, 26, 0};
    int px[189];
    int py[189];
    int cum[6];
    int lap_len;
    bit m_run, m_at, m_lap;
    int m_k;

    task automatic build_path();
        int cx, cy, k, t;
        cx = wx[0]; cy = wy[0]; k = 0;
        px[0] = cx; py[0] = cy;
        for (int s = 1; s <= 6; s++) begin
            t = s % 6;
            while ((cx != wx[t] || cy != wy[t]) && k < 188) begin
                if (cx < wx[t]) cx++; else if (cx > wx[t]) cx--;
                if (cy < wy[t]) cy++; else if (cy > wy[t]) cy--;
                k++;
                px[k] = cx; py[k] = cy;
            end
            cum[s-1] = k;
        end
        lap_len = k;
    endtask

    function automatic logic [18:0] exp_vec();
        int c;
        logic [2:0] s;
        if (!m_run) return {7'd84, 6'd0, 3'd0, 1'b0, m_at, m_lap};
        c = 0;
        for (int j = 0; j < 5; j++) if (cum[j] <= m_k) c++;
        s = 3'((1 + c) % 6);
        return {7'(px[m_k]), 6'(py[m_k]), s, 1'b1, m_at, m_lap};
    endfunction

    task automatic model_update();
        m_at = 0; m_lap = 0;
        if (reset || !enable) begin
            m_run = 0; m_k = 0;
        end else if (!m_run) begin
            if (start) begin m_run = 1; m_k = 0; end
        end else if (step_tick && !pause) begin
            m_k++;
            for (int j = 0; j < 6; j++) if (cum[j] == m_k) m_at = 1;
            if (m_k == lap_len) begin
                m_lap = 1; m_k = 0;
                if (!loop_mode) m_run = 0;
            end
        end
    endtask

    task automatic step(input bit t, input bit p, input bit s);
        step_tick = t; pause = p; start = s;
        @(posedge clk);
        model_update();
        @(negedge clk);
        step_tick = 0; start = 0;
    endtask

    task automatic do_reset();
        reset = 1; enable = 1; pause = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (obs !== {7'd84, 6'd0, 3'd0, 3'b000}) begin
            fails++; $display("FAIL reset_state got=%h want=%h", obs, {7'd84, 6'd0, 3'd0, 3'b000});
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            tests++;
            if (obs !== {7'd84, 6'd0, 3'd0, 3'b000}) begin
                fails++; $display("FAIL idle_ticks i=%0d got=%h want=%h", i, obs, {7'd84, 6'd0, 3'd0, 3'b000});
            end
        end
    endtask

    task automatic test_first_segment();
        int n_at = 0;
        do_reset();
        loop_mode = 0;
        step(0, 0, 1);
        tests++;
        if ({busy, seg_idx} !== 4'b1_001) begin
            fails++; $display("FAIL start_busy got=%b want=1001", {busy, seg_idx});
        end
        for (int i = 0; i < 52; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                step(0, 0, 0);
                if (at_wp) n_at++;
            end
            step(1, 0, 0);
            if (at_wp) n_at++;
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL seg1_walk i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        tests++;
        if ({pos_x, pos_y, seg_idx} !== {7'd84, 6'd52, 3'd2} || n_at != 1) begin
            fails++; $display("FAIL seg1_end got=(%0d,%0d) seg=%0d at=%0d want=(84,52) seg=2 at=1",
                              pos_x, pos_y, seg_idx, n_at);
        end
    endtask

    task automatic test_full_lap();
        do_reset();
        loop_mode = 0;
        step(0, 0, 1);
        for (int i = 1; i <= 188; i++) begin
            step(1, 0, 0);
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL lap_walk i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        tests++;
        if ({pos_x, pos_y, busy, at_wp, lap_done} !== {7'd84, 6'd0, 3'b011}) begin
            fails++; $display("FAIL lap_end got=%h want=%h", {pos_x, pos_y, busy, at_wp, lap_done},
                              {7'd84, 6'd0, 3'b011});
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        tests++;
        if (obs !== {7'd84, 6'd0, 3'd0, 3'b000}) begin
            fails++; $display("FAIL after_lap got=%h want=%h", obs, {7'd84, 6'd0, 3'd0, 3'b000});
        end
    endtask

    task automatic test_loop();
        int laps = 0;
        do_reset();
        loop_mode = 1;
        step(0, 0, 1);
        for (int i = 1; i <= 376; i++) begin
            step(1, 0, 0);
            tests++;
            if (busy !== 1'b1 || obs !== exp_vec()) begin
                fails++; $display("FAIL loop_walk i=%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (lap_done) begin
                laps++;
                tests++;
                if (seg_idx !== 3'd1 || (i != 188 && i != 376)) begin
                    fails++; $display("FAIL loop_lap i=%0d seg=%0d want seg=1 at tick 188/376", i, seg_idx);
                end
            end
        end
        tests++;
        if (laps != 2) begin
            fails++; $display("FAIL loop_count got=%0d want=2", laps);
        end
        loop_mode = 0;
    endtask

    task automatic test_pause();
        do_reset();
        step(0, 0, 1);
        for (int i = 0; i < 30; i++) step(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0);
            tests++;
            if ({pos_x, pos_y, busy} !== {7'd84, 6'd30, 1'b1}) begin
                fails++; $display("FAIL paused i=%0d got=(%0d,%0d) want=(84,30)", i, pos_x, pos_y);
            end
        end
        for (int i = 0; i < 22; i++) step(1, 0, 0);
        tests++;
        if ({pos_x, pos_y, seg_idx, at_wp} !== {7'd84, 6'd52, 3'd2, 1'b1}) begin
            fails++; $display("FAIL pause_resume got=(%0d,%0d) seg=%0d at=%b want=(84,52) seg=2 at=1",
                              pos_x, pos_y, seg_idx, at_wp);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        step(0, 0, 1);
        for (int i = 0; i < 106; i++) step(1, 0, 0);
        tests++;
        if ({pos_x, pos_y} !== {7'd42, 6'd40}) begin
            fails++; $display("FAIL reach_42_40 got=(%0d,%0d) want=(42,40)", pos_x, pos_y);
        end
        enable = 0;
        step(1, 0, 0);
        tests++;
        if (obs !== {7'd84, 6'd0, 3'd0, 3'b000}) begin
            fails++; $display("FAIL enable_drop got=%h want=%h", obs, {7'd84, 6'd0, 3'd0, 3'b000});
        end
        enable = 1;
        step(1, 0, 1);
        tests++;
        if ({pos_x, pos_y, seg_idx, busy} !== {7'd84, 6'd0, 3'd1, 1'b1}) begin
            fails++; $display("FAIL restart got=(%0d,%0d) seg=%0d busy=%b want=(84,0) seg=1 busy=1",
                              pos_x, pos_y, seg_idx, busy);
        end
        step(1, 0, 1);
        tests++;
        if ({pos_x, pos_y, seg_idx} !== {7'd84, 6'd1, 3'd1} || obs !== exp_vec()) begin
            fails++; $display("FAIL start_in_run got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) loop_mode = ~loop_mode;
            enable = ($urandom_range(0, 699) != 0);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            tests++;
            if (obs !== exp_vec()) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL random i=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        enable = 1; loop_mode = 0;
    endtask

    initial begin
        build_path();
        m_run = 0; m_k = 0; m_at = 0; m_lap = 0;
        test_reset();
        test_first_segment();
        test_full_lap();
        test_loop();
        test_pause();
        test_enable_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
